pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencer for the five-stage LC-3b pipeline. Each cycle it combines the ID-stage load-use stall, the instruction and data memory wait conditions, and the MEM-stage branch/redirect request. From these it drives the load enables and flush strobes of the PC and the four pipeline registers, plus the PC mux select. It also runs a post-reset flush sequence, a memory-freeze watchdog and optional performance counters.

## Interface
- TIMEOUT_CYCLES, 255: consecutive freeze cycles before `mem_timeout` sets; legal range 1..65535.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- hazard_stall  in  1  load-use stall from the ID-stage hazard unit.
- imem_req  in  1  IF stage has an instruction fetch outstanding.
- imem_resp  in  1  instruction memory response this cycle.
- dmem_req  in  1  MEM stage has a load/store outstanding.
- dmem_resp  in  1  data memory response this cycle.
- br_taken  in  1  MEM stage requests PC redirect (taken branch, JMP, JSR, TRAP).
- load_pc  out  1  PC register enable.
- pcmux_sel  out  1  0 = sequential PC+2, 1 = redirect target.
- load_ifid, load_idex, load_exmem, load_memwb  out  1 each  pipeline register enables.
- flush_ifid, flush_idex, flush_exmem  out  1 each  load a NOP/invalid control word instead of upstream data; only meaningful with the matching load high.
- mem_timeout  out  1  sticky watchdog flag.
- perf_freeze, perf_bubble, perf_redirect  out  32 each  counters (only with the perf macro).

## Operation
- Wait terms: `imem_wait = imem_req & ~imem_resp`; `dmem_wait = dmem_req & ~dmem_resp`; `wait = imem_wait | dmem_wait`.
- `redir = br_taken | redirect_pend`.
- States: INIT, RUN, FREEZE.
- **INIT** (entered while rst_n low):
  - All four loads = 1; all three flushes = 1; load_pc = 0; pcmux_sel = 0.
  - On the first rising edge after rst_n high, go to RUN.
- **RUN / FREEZE** output rules, evaluated in priority order:
  1. `wait`: all loads 0, load_pc 0, flushes 0; next state FREEZE. If br_taken = 1, set redirect_pend.
  2. `redir`: all loads 1, load_pc 1, pcmux_sel 1, flush_ifid = flush_idex = flush_exmem = 1; clear redirect_pend; next state RUN.
  3. `hazard_stall`: load_pc 0, load_ifid 0, load_idex 1 with flush_idex 1 (bubble), load_exmem 1, load_memwb 1; next state RUN.
  4. Otherwise: all loads 1, load_pc 1, pcmux_sel 0, flushes 0; next state RUN.
- A redirect beats a load-use stall: the stalled instruction is on the wrong path.
- A memory wait beats a redirect. The outstanding access must complete first. The fetched instruction is then discarded by flush_ifid.
- **Watchdog**:
  - freeze_cnt increments each cycle in FREEZE with `wait` high, and clears on leaving FREEZE.
  - When freeze_cnt reaches TIMEOUT_CYCLES, mem_timeout sets and stays set until reset.
  - freeze_cnt saturates.
- Reset values: state INIT, redirect_pend 0, freeze_cnt 0, mem_timeout 0, perf counters 0.

## Timing
- All outputs are combinational from current state, redirect_pend and the inputs. No added latency.
- Redirect takes effect on the same edge that br_taken is seen, with no wait pending. The target instruction is fetched the following cycle.
- Load-use stall produces exactly one bubble per cycle that hazard_stall is high.
- Freeze exit: the first cycle with `wait` low applies rules 2–4 in that same cycle.
- Simultaneous imem and dmem waits: a single freeze, lasting until both complete.
- Reset mid-freeze or mid-redirect: redirect_pend is dropped, and INIT flushes all stages.
- br_taken pulsing during a freeze is not lost; it is held in redirect_pend.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - perf_freeze counts FREEZE cycles.
  - perf_bubble counts rule-3 cycles.
  - perf_redirect counts rule-2 cycles.
  - All 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: the counters are not built and the three perf ports read constant 0.

## Structure
- Shared `lc3b_types` package holds:
  - `pipe_ctrl_state_t` enum {INIT, RUN, FREEZE}.
  - `lc3b_perf_cnt` (32-bit) typedef.
- One sub-module, `sat_counter` (parameter width; ports inc, clr, count), used for freeze_cnt and the perf counters.

## Test plan
- Hold rst_n low 3 cycles, then release → every cycle of reset and the first cycle after: flushes all 1, load_pc 0; second cycle: RUN with all loads 1, pcmux_sel 0.
- hazard_stall high 1 cycle in RUN → load_pc 0, load_ifid 0, flush_idex 1, load_exmem 1; next cycle normal; perf_bubble = 1.
- br_taken and hazard_stall together → pcmux_sel 1, load_pc 1, three flushes 1, no bubble; perf_redirect = 1.
- dmem_req high with dmem_resp low 4 cycles, br_taken pulsed in cycle 2 → all loads 0 for 4 cycles; cycle 5 (resp) performs the redirect; perf_freeze = 4.
- TIMEOUT_CYCLES = 8, imem_req stuck with no resp → mem_timeout rises after 8 freeze cycles; stays 1 after resp arrives; clears only on rst_n low.
- rst_n dropped during a freeze with redirect_pend set → immediate INIT outputs; after release, no redirect is issued.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared LC-3b pipeline types: sequencer state encoding and perf counter width.
package lc3b_types;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } pipe_ctrl_state_t;

  typedef logic [31:0] lc3b_perf_cnt;

  // 16 bits covers the full legal TIMEOUT_CYCLES range (up to 65535).
  localparam int FREEZE_CNT_W = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count <= '0;
    else if (clr)                    count <= '0;
    else if (inc && (count != '1))   count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// LC-3b five-stage pipeline sequencer: stall/freeze/redirect arbitration, watchdog.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_stall,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        br_taken,
  output logic        load_pc,
  output logic        pcmux_sel,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        load_exmem,
  output logic        load_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        mem_timeout,
  output logic [31:0] perf_freeze,
  output logic [31:0] perf_bubble,
  output logic [31:0] perf_redirect
);

  pipe_ctrl_state_t        r_state, w_next;
  logic                    r_pend, w_pend_nxt;
  logic                    w_wait, w_redir;
  logic                    w_fc_inc;
  logic [FREEZE_CNT_W-1:0] w_fcnt;
  logic                    r_timeout;

  assign w_wait  = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
  assign w_redir = br_taken | r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pend_nxt  = r_pend;
    load_pc     = 1'b0;
    pcmux_sel   = 1'b0;
    load_ifid   = 1'b0;
    load_idex   = 1'b0;
    load_exmem  = 1'b0;
    load_memwb  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    case (r_state)
      INIT: begin
        {load_ifid, load_idex, load_exmem, load_memwb} = 4'b1111;
        {flush_ifid, flush_idex, flush_exmem}          = 3'b111;
        w_pend_nxt = 1'b0;
        w_next     = RUN;
      end
      default: begin
        if (w_wait) begin
          // Hold a redirect seen mid-freeze so it is not lost.
          if (br_taken) w_pend_nxt = 1'b1;
          w_next = FREEZE;
        end else if (w_redir) begin
          {load_ifid, load_idex, load_exmem, load_memwb} = 4'b1111;
          {flush_ifid, flush_idex, flush_exmem}          = 3'b111;
          load_pc    = 1'b1;
          pcmux_sel  = 1'b1;
          w_pend_nxt = 1'b0;
          w_next     = RUN;
        end else if (hazard_stall) begin
          {load_idex, load_exmem, load_memwb} = 3'b111;
          flush_idex = 1'b1;
          w_next     = RUN;
        end else begin
          {load_ifid, load_idex, load_exmem, load_memwb} = 4'b1111;
          load_pc = 1'b1;
          w_next  = RUN;
        end
      end
    endcase
  end

  // Watchdog: counts consecutive frozen cycles still waiting on memory.
  assign w_fc_inc = (r_state == FREEZE) & w_wait;

  sat_counter #(.W(FREEZE_CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_fc_inc),
    .clr   (~w_fc_inc),
    .count (w_fcnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_timeout <= 1'b0;
    else if (w_fc_inc && (({1'b0, w_fcnt} + 17'd1) >= 17'(TIMEOUT_CYCLES)))
      r_timeout <= 1'b1;
  end

  assign mem_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  lc3b_perf_cnt w_pf, w_pb, w_pr;

  sat_counter #(.W(32)) u_perf_freeze (
    .clk(clk), .rst_n(rst_n), .inc(r_state == FREEZE), .clr(1'b0), .count(w_pf)
  );
  // A bubble is the only case holding IF/ID while loading ID/EX.
  sat_counter #(.W(32)) u_perf_bubble (
    .clk(clk), .rst_n(rst_n), .inc(~load_ifid & load_idex), .clr(1'b0), .count(w_pb)
  );
  sat_counter #(.W(32)) u_perf_redirect (
    .clk(clk), .rst_n(rst_n), .inc(pcmux_sel), .clr(1'b0), .count(w_pr)
  );

  assign perf_freeze   = w_pf;
  assign perf_bubble   = w_pb;
  assign perf_redirect = w_pr;
`else
  assign perf_freeze   = '0;
  assign perf_bubble   = '0;
  assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a behavioural rule model.
module tb_pipeline_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard_stall = 1'b0, imem_req = 1'b0, imem_resp = 1'b0;
  logic        dmem_req = 1'b0, dmem_resp = 1'b0, br_taken = 1'b0;
  logic        load_pc, pcmux_sel, load_ifid, load_idex, load_exmem, load_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, mem_timeout;
  logic [31:0] perf_freeze, perf_bubble, perf_redirect;

  pipeline_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken(br_taken),
    .load_pc(load_pc), .pcmux_sel(pcmux_sel),
    .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .mem_timeout(mem_timeout),
    .perf_freeze(perf_freeze), .perf_bubble(perf_bubble), .perf_redirect(perf_redirect)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ld_pc, pcmux, l_ifid, l_idex, l_exmem, l_memwb, f_ifid, f_idex, f_exmem, tmo;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    int unsigned pf, pb, pr;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   drv_done = 0;

  // Reference model state, described in terms of the spec rules.
  bit          m_init = 1, m_frozen = 0, m_pend = 0, m_tmo = 0;
  int          m_fcnt = 0;
  int unsigned m_pf = 0, m_pb = 0, m_pr = 0;

  task automatic step(input bit rst, hz, ir, irs, dr, drs, br);
    exp_t e;
    bit   w;
    int   rule;
    @(negedge clk);
    rst_n = rst; hazard_stall = hz; imem_req = ir; imem_resp = irs;
    dmem_req = dr; dmem_resp = drs; br_taken = br;
    if (!rst) begin
      m_init = 1; m_frozen = 0; m_pend = 0; m_tmo = 0; m_fcnt = 0;
      m_pf = 0; m_pb = 0; m_pr = 0;
    end
    e.c = '0;
    e.c.tmo = m_tmo;
    e.pf = m_pf; e.pb = m_pb; e.pr = m_pr;
    if (m_init) begin
      {e.c.l_ifid, e.c.l_idex, e.c.l_exmem, e.c.l_memwb} = 4'b1111;
      {e.c.f_ifid, e.c.f_idex, e.c.f_exmem} = 3'b111;
      if (rst) m_init = 0;
    end else begin
      w = (ir && !irs) || (dr && !drs);
      if (w)                 rule = 1;
      else if (br || m_pend) rule = 2;
      else if (hz)           rule = 3;
      else                   rule = 4;
      case (rule)
        2: begin
          e.c.ld_pc = 1; e.c.pcmux = 1;
          {e.c.l_ifid, e.c.l_idex, e.c.l_exmem, e.c.l_memwb} = 4'b1111;
          {e.c.f_ifid, e.c.f_idex, e.c.f_exmem} = 3'b111;
        end
        3: begin
          {e.c.l_idex, e.c.l_exmem, e.c.l_memwb} = 3'b111;
          e.c.f_idex = 1;
        end
        4: begin
          e.c.ld_pc = 1;
          {e.c.l_ifid, e.c.l_idex, e.c.l_exmem, e.c.l_memwb} = 4'b1111;
        end
        default: ;
      endcase
      if (m_frozen)  m_pf++;
      if (rule == 3) m_pb++;
      if (rule == 2) m_pr++;
      if (m_frozen && w) m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
      else               m_fcnt = 0;
      if (m_fcnt >= TO) m_tmo = 1;
      if (rule == 1)      m_pend = m_pend | br;
      else if (rule == 2) m_pend = 0;
      m_frozen = (rule == 1);
    end
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a control word; compare it mid-cycle.
  initial begin
    exp_t        e;
    ctl_t        act;
    logic [95:0] pact, pexp;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = '{load_pc, pcmux_sel, load_ifid, load_idex, load_exmem, load_memwb,
                flush_ifid, flush_idex, flush_exmem, mem_timeout};
        n_vec++;
        if (act !== e.c) begin
          n_err++;
          $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.c);
        end
`ifdef PIPE_CTRL_PERF_EN
        pexp = {e.pf, e.pb, e.pr};
`else
        pexp = '0;
`endif
        pact = {perf_freeze, perf_bubble, perf_redirect};
        n_vec++;
        if (pact !== pexp) begin
          n_err++;
          $display("FAIL perf @%0t: got %h expected %h", $time, pact, pexp);
        end
      end
    end
  end

  initial begin
    bit stuck_i, stuck_d;
    // Reset held for 3 cycles, then release into INIT for one cycle, then RUN.
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Single load-use stall, then normal.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Redirect beats stall.
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    // Data wait 4 cycles with branch in cycle 2; redirect on response.
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Simultaneous imem and dmem waits, imem finishing first.
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    // Instruction fetch stuck long enough to trip the watchdog.
    repeat (12) step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    // Reset during a freeze with a pending redirect: no redirect after release.
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    // Random traffic with occasional long stalls and resets.
    stuck_i = 0; stuck_d = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) stuck_i = ~stuck_i;
      if ($urandom_range(0, 39) == 0) stuck_d = ~stuck_d;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1) || stuck_i,
           !stuck_i && ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0) || stuck_d,
           !stuck_d && ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 5) == 0));
    end
    drv_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!(drv_done && q.size() == 0) && guard < 5000) begin
      @(negedge clk);
      #3;
      guard++;
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
